// File: rtl/vga_scanout.sv
// VGA scanout: drains a show-ahead pixel FIFO at pixel rate during the visible region
// and generates registered rgb/hsync/vsync/blank aligned to each other.
module vga_scanout #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  input  logic [23:0] fifo_data,
  input  logic        fifo_empty,
  input  logic        fifo_full,
  output logic        fifo_rd_en,
  output logic [23:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        frame_start,
  output logic        underflow
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HAct      = 10'(H_ACTIVE);
  localparam logic [9:0] HSyncBeg  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HSyncEnd  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] HLast     = 10'(HTotal - 1);
  localparam logic [9:0] VAct      = 10'(V_ACTIVE);
  localparam logic [9:0] VSyncBeg  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VSyncEnd  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] VLast     = 10'(VTotal - 1);

  typedef enum logic [0:0] {StPrime, StRun} state_e;

  state_e      state_q, state_d;
  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [23:0] rgb_q, rgb_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        blank_q, blank_d;
  logic        frame_start_q, frame_start_d;
  logic        underflow_q, underflow_d;

  logic run_ce;
  logic visible;
  logic h_sync_on;
  logic v_sync_on;

  assign run_ce    = (state_q == StRun) && pix_ce;
  assign visible   = (h_cnt_q < HAct) && (v_cnt_q < VAct);
  assign h_sync_on = (h_cnt_q >= HSyncBeg) && (h_cnt_q < HSyncEnd);
  assign v_sync_on = (v_cnt_q >= VSyncBeg) && (v_cnt_q < VSyncEnd);

  // Show-ahead FIFO: the head is consumed on the same edge that captures it into rgb.
  assign fifo_rd_en = run_ce && visible && !fifo_empty;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StPrime: if (pix_ce && fifo_full) state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StPrime;
    endcase
  end

  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    rgb_d         = rgb_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    blank_d       = blank_q;
    underflow_d   = underflow_q;
    frame_start_d = run_ce && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);

    if (run_ce) begin
      rgb_d   = fifo_rd_en ? fifo_data : 24'h0;
      blank_d = !visible;
      hsync_d = h_sync_on ? SYNC_POL : ~SYNC_POL;
      vsync_d = v_sync_on ? SYNC_POL : ~SYNC_POL;
      if (visible && fifo_empty) underflow_d = 1'b1;

      // Raster never stalls on underflow; timing stays locked to pix_ce.
      if (h_cnt_q == HLast) begin
        h_cnt_d = 10'd0;
        v_cnt_d = (v_cnt_q == VLast) ? 10'd0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StPrime;
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      rgb_q         <= 24'h0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      blank_q       <= 1'b1;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
    end
  end

  assign rgb         = rgb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank       = blank_q;
  assign frame_start = frame_start_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout on a shrunken raster (15x8) so several frames fit quickly.
module tb_vga_scanout;

  localparam int HA = 8, HFP = 2, HS = 3, HB = 2;
  localparam int VA = 4, VFP = 1, VS = 2, VB = 1;
  localparam int HT = HA + HFP + HS + HB;
  localparam int VT = VA + VFP + VS + VB;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_ce;
  logic [23:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_full;
  logic        fifo_rd_en;
  logic [23:0] rgb;
  logic        hsync, vsync, blank, frame_start, underflow;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_ce     (pix_ce),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .fifo_rd_en (fifo_rd_en),
    .rgb        (rgb),
    .hsync      (hsync),
    .vsync      (vsync),
    .blank      (blank),
    .frame_start(frame_start),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] rgb;
    logic        blank;
    logic        hsync;
    logic        vsync;
    logic        fs;
    logic        uf;
  } exp_t;

  localparam exp_t ResetExp = '{rgb: 24'h0, blank: 1'b1, hsync: 1'b1, vsync: 1'b1,
                                fs: 1'b0, uf: 1'b0};

  exp_t        sb[$];
  exp_t        held;
  int          checks = 0;
  int          failures = 0;
  bit          m_run;
  int          m_h, m_v, m_frame;
  logic [23:0] m_pix;
  logic        m_uf;
  logic [23:0] pat;
  int          pops, fs_seen, ce_in_run;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rgb"}, 32'(rgb), 32'h0);
    chk({tag, "_blank"}, 32'(blank), 32'h1);
    chk({tag, "_hsync"}, 32'(hsync), 32'h1);
    chk({tag, "_vsync"}, 32'(vsync), 32'h1);
    chk({tag, "_fs"}, 32'(frame_start), 32'h0);
    chk({tag, "_uf"}, 32'(underflow), 32'h0);
    chk({tag, "_rd"}, 32'(fifo_rd_en), 32'h0);
  endtask

  // One clk: drive at negedge, model predicts, check pop before the edge and outputs after it.
  task automatic step(input bit ce, input bit empty, input bit full);
    exp_t e;
    bit   exp_rd, vis, obs_rd;
    @(negedge clk);
    pix_ce     = ce;
    fifo_empty = empty;
    fifo_full  = full;
    fifo_data  = empty ? 24'hdead5a : pat;
    exp_rd = 1'b0;
    e      = held;
    e.fs   = 1'b0;
    if (m_run && ce) begin
      vis     = (m_h < HA) && (m_v < VA);
      exp_rd  = vis && !empty;
      e.rgb   = exp_rd ? m_pix : 24'h0;
      e.blank = !vis;
      e.hsync = !((m_h >= HA + HFP) && (m_h < HA + HFP + HS));
      e.vsync = !((m_v >= VA + VFP) && (m_v < VA + VFP + VS));
      e.fs    = (m_h == 0) && (m_v == 0);
      if (vis && empty) m_uf = 1'b1;
      e.uf = m_uf;
      if (exp_rd) m_pix++;
      if (e.fs) m_frame++;
      ce_in_run++;
      if (m_h == HT - 1) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h++;
      end
    end else if (!m_run && ce && full) begin
      m_run = 1'b1;
    end
    held = e;
    sb.push_back(e);
    #1;
    chk("rd_en", 32'(fifo_rd_en), 32'(exp_rd));
    obs_rd = fifo_rd_en;
    if (obs_rd) pops++;
    @(posedge clk);
    #1;
    if (obs_rd) pat++;
    e = sb.pop_front();
    chk("rgb", 32'(rgb), 32'(e.rgb));
    chk("blank", 32'(blank), 32'(e.blank));
    chk("hsync", 32'(hsync), 32'(e.hsync));
    chk("vsync", 32'(vsync), 32'(e.vsync));
    chk("frame_start", 32'(frame_start), 32'(e.fs));
    chk("underflow", 32'(underflow), 32'(e.uf));
    if (frame_start) fs_seen++;
  endtask

  initial begin
    bit ce, done, emp;
    int pops_f1, ce_f1, pops_hold, fs_hold;
    rst = 1'b1; pix_ce = 1'b0; fifo_empty = 1'b0; fifo_full = 1'b0; fifo_data = 24'h0;
    m_run = 1'b0; m_h = 0; m_v = 0; m_frame = 0; m_pix = 24'h0; m_uf = 1'b0;
    pat = 24'h0; pops = 0; fs_seen = 0; ce_in_run = 0;
    pops_f1 = 0; ce_f1 = 0; done = 1'b0;
    held = ResetExp;
    #23;
    chk_reset("por");
    @(negedge clk);
    rst = 1'b0;

    // FIFO never full: must stay primed with reset outputs.
    for (int i = 0; i < 400; i++) step(i % 4 == 0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);

    // Three frames; FIFO starves for 3 visible pixels on line 1 of the first frame.
    for (int i = 0; i < 5000 && !done; i++) begin
      ce = ($urandom_range(0, 2) != 0);
      if (ce && m_h == 0 && m_v == 0) begin
        if (m_frame == 1) begin
          pops_f1 = pops;
          ce_f1   = ce_in_run;
        end else if (m_frame == 3) begin
          chk("pops_frame0", 32'(pops_f1), 32'(HA * VA - 3));
          chk("pops_2frames", 32'(pops - pops_f1), 32'(2 * HA * VA));
          chk("frame_len", 32'(ce_in_run - ce_f1), 32'(2 * HT * VT));
          chk("fs_count", 32'(fs_seen), 32'd3);
          done = 1'b1;
        end
      end
      if (!done) begin
        emp = (m_frame == 1) && (m_v == 1) && (m_h >= 3) && (m_h < 6);
        step(ce, emp, 1'b1);
      end
    end
    chk("frames_done", 32'(done), 32'd1);

    // Advance to pixel (5,2) and reset asynchronously mid-frame.
    for (int i = 0; i < 2000 && !(m_h == 5 && m_v == 2); i++) step($urandom_range(0, 1) == 1, 1'b0, 1'b1);
    chk("reached_mid", 32'(m_h == 5 && m_v == 2), 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("async_rst");
    m_run = 1'b0; m_h = 0; m_v = 0; m_uf = 1'b0;
    held = ResetExp;
    @(posedge clk);
    #1;
    chk_reset("rst_held");
    rst = 1'b0;

    pops_hold = pops;
    for (int i = 0; i < 60; i++) step($urandom_range(0, 1) == 1, 1'b0, 1'b0);
    chk("no_pops_prime", 32'(pops), 32'(pops_hold));

    fs_hold = fs_seen;
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b1);
    chk("fs_after_rst", 32'(fs_seen), 32'(fs_hold + 1));
    chk("pops_after_rst", 32'(pops - pops_hold), 32'(HA));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Consumer end of the display pixel FIFO. Pops 24-bit RGB pixels from a show-ahead FIFO during the visible region of a 640x480@60 raster and generates the matching hsync, vsync and blank signals for the VGA DAC. The upscaling fill logic upstream writes the FIFO, and this block drains it at pixel rate.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync asserted level (0 = active-low)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- pix_ce  in  1  pixel clock enable (one pulse per pixel, 25 MHz nominal)
- fifo_data  in  24  FIFO head word; valid whenever fifo_empty=0
- fifo_empty  in  1  FIFO empty flag
- fifo_full  in  1  FIFO full flag
- fifo_rd_en  out  1  pop FIFO head this clk
- rgb  out  24  pixel {R[23:16],G[15:8],B[7:0]}, registered
- hsync  out  1  horizontal sync, registered
- vsync  out  1  vertical sync, registered
- blank  out  1  1 outside the visible region, registered
- frame_start  out  1  one-clk pulse at pixel (0,0) of each frame
- underflow  out  1  sticky: FIFO was empty on a required pop

## Operation
- Counters: h_cnt 10 bits, 0..H_TOTAL-1 (H_TOTAL = sum of H params = 800). v_cnt 10 bits, 0..V_TOTAL-1 (525). Both advance only on pix_ce.
- h_cnt wraps to 0 at 799. v_cnt increments when h_cnt wraps and itself wraps to 0 at 524.
- Visible when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- hsync asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 656..751.
- vsync asserted for v_cnt in [490, 492).
- FSM with 2 states:
  - PRIME: counters held at 0, no pops, outputs at reset values. Go to RUN on the first pix_ce with fifo_full=1.
  - RUN: free-running raster. Stays in RUN until reset.
- In RUN, when pix_ce=1 and visible and fifo_empty=0: fifo_rd_en=1 (combinational), and rgb <= fifo_data.
- In RUN, when pix_ce=1 and visible and fifo_empty=1: no pop, rgb <= 0, underflow <= 1. Counters do not stall.
- When not visible: rgb <= 0, no pop.
- fifo_rd_en is never asserted outside RUN, without pix_ce, or with fifo_empty=1.
- frame_start pulses for one clk when pix_ce=1 in RUN with h_cnt=0 and v_cnt=0, including the first RUN pixel.
- Total pops per frame is exactly 640*480 = 307200 when no underflow occurs.

## Timing
- Reset values: fifo_rd_en=0, rgb=0, blank=1, hsync=vsync=~SYNC_POL (deasserted), frame_start=0, underflow=0, state=PRIME, h_cnt=v_cnt=0.
- rgb, blank, hsync and vsync are registered together on the same pix_ce edge, so they are mutually aligned with one pix_ce of latency from the counter value.
- The pop and the rgb capture happen on the same clk. The FIFO head advances after that edge.
- Reset mid-frame: all registers return to reset values immediately (async). The block re-enters PRIME and waits for fifo_full again.
- underflow is cleared only by rst.
- pix_ce held low: everything freezes, and fifo_rd_en=0.

## Test plan
- Reset with pix_ce toggling every 4th clk and FIFO never full -> stays in PRIME. blank=1, hsync=vsync=1, fifo_rd_en=0 for 10000 clks.
- Assert fifo_full, FIFO holds an incrementing pattern -> frame_start on the first RUN pixel. rgb shows 0x000000, 0x000001, ... with blank=0 for pixels 0..639. Exactly 640 pops per line.
- Sync timing over a full frame -> hsync low for exactly 96 pix_ce starting at h_cnt 656. vsync low for exactly 2 lines starting at line 490. Frame lasts 800*525 = 420000 pix_ce.
- Empty the FIFO at visible pixel (100,5) for 3 pixels -> rgb=0 for those pixels, no fifo_rd_en, underflow rises and stays 1. Raster timing is unchanged.
- Assert rst at h_cnt=300, v_cnt=200 -> outputs return to reset values in the same cycle. PRIME is re-entered, and there are no pops until fifo_full=1.
- Frame wrap (h=799, v=524 -> 0,0) -> frame_start pulses once per frame. Total pops over 2 frames = 614400.
